// File: rtl/seg_dynamic_scan_if.sv
// seg_dynamic_scan_if: display value inputs and multiplexed digit-select/segment outputs.
interface seg_dynamic_scan_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;
  modport master (output data, point, sign, seg_en, input sel, seg);
  modport slave  (input data, point, sign, seg_en, output sel, seg);
endinterface

// File: rtl/seg_dynamic_scan.sv
// seg_dynamic_scan: double-dabble binary-to-BCD converter feeding a 6-digit multiplexed 7-segment scanner.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros and float the minus sign next to the MSD.
module seg_dynamic_scan #(
  parameter int CNT_MAX = 49999
) (
  input logic sys_clk,
  input logic sys_rst_n,
  seg_dynamic_scan_if.slave bus
);
  localparam int DW = $clog2(CNT_MAX + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(CNT_MAX);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [19:0] w_clamp;
  logic [43:0] r_dd;
  logic [23:0] w_adj, r_buf;
  logic r_sign, r_buf_sign;
  logic [4:0] r_shift_cnt;
  logic [DW-1:0] r_dwell;
  logic w_flag;
  logic [2:0] r_idx;
  logic [3:0] w_nib;
  logic [6:0] w_num, w_pat;
  logic [5:0] r_sel;
  logic [7:0] r_seg;
  assign w_clamp = bus.sign ? (bus.data > 20'd99999 ? 20'd99999 : bus.data)
                            : (bus.data > 20'd999999 ? 20'd999999 : bus.data);
  for (genvar i = 0; i < 6; i++) begin : g_adj
    assign w_adj[4*i +: 4] = r_dd[20+4*i +: 4] >= 4'd5 ? r_dd[20+4*i +: 4] + 4'd3 : r_dd[20+4*i +: 4];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? SHIFT :
             r_state == SHIFT ? (r_shift_cnt == 5'd19 ? DONE : SHIFT) : IDLE;
  end
  // {bcd, bin} shift as one register so the carry-out of the binary half feeds the BCD half
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_dd        <= '0;
      r_sign      <= 1'b0;
      r_shift_cnt <= '0;
      r_buf       <= '0;
      r_buf_sign  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dd        <= {24'd0, w_clamp};
          r_sign      <= bus.sign;
          r_shift_cnt <= '0;
        end
        SHIFT: begin
          r_dd        <= {w_adj, r_dd[19:0]} << 1;
          r_shift_cnt <= r_shift_cnt + 5'd1;
        end
        DONE: begin
          r_buf      <= r_dd[43:20];
          r_buf_sign <= r_sign;
        end
        default: ;
      endcase
    end
  assign w_flag = r_dwell == DWELL_MAX;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_dwell <= '0;
      r_idx   <= '0;
    end else begin
      r_dwell <= w_flag ? '0 : r_dwell + 1'b1;
      if (w_flag) r_idx <= r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1;
    end
  assign w_nib = r_buf[{r_idx, 2'b00} +: 4];
  always_comb begin
    w_num = 7'h7F;
    case (w_nib)
      4'd0: w_num = 7'h40;
      4'd1: w_num = 7'h79;
      4'd2: w_num = 7'h24;
      4'd3: w_num = 7'h30;
      4'd4: w_num = 7'h19;
      4'd5: w_num = 7'h12;
      4'd6: w_num = 7'h02;
      4'd7: w_num = 7'h78;
      4'd8: w_num = 7'h00;
      4'd9: w_num = 7'h10;
      default: w_num = 7'h7F;
    endcase
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;
  always_comb begin
    w_msd = 3'd0;
    for (int d = 1; d < 6; d++)
      if (r_buf[4*d +: 4] != 4'd0) w_msd = 3'(d);
  end
  // digit 0 is never above the MSD, so a zero value still shows "0"
  assign w_pat = r_idx > w_msd ? ((r_buf_sign && r_idx == w_msd + 3'd1) ? 7'h3F : 7'h7F) : w_num;
`else
  assign w_pat = (r_buf_sign && r_idx == 3'd5) ? 7'h3F : w_num;
`endif
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_sel <= '0;
      r_seg <= 8'hFF;
    end else begin
      r_sel <= bus.seg_en ? 6'b1 << r_idx : 6'd0;
      r_seg <= bus.seg_en ? {~bus.point[r_idx], w_pat} : 8'hFF;
    end
  assign bus.sel = r_sel;
  assign bus.seg = r_seg;
endmodule

// File: tb/tb_seg_dynamic_scan.sv
// tb_seg_dynamic_scan: directed and random stimulus checked cycle-by-cycle against a timing/arithmetic reference model.
module tb_seg_dynamic_scan;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  seg_dynamic_scan_if bus();
  seg_dynamic_scan #(.CNT_MAX(9)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus.slave));
  always #5 sys_clk = ~sys_clk;
  int n_assert = 0;
  int n_fail = 0;
  int k = 0;
  int buf_val = 0;
  int pend_val = 0;
  bit buf_sgn = 1'b0;
  bit pend_sgn = 1'b0;
  logic [7:0] num_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  function automatic int clamp(int d, bit s);
    int lim = s ? 99999 : 999999;
    return d > lim ? lim : d;
  endfunction
  function automatic logic [7:0] exp_seg(int v, bit s, logic [5:0] pt, int d);
    int digs[6];
    int t = v;
    int msd = 0;
    logic [7:0] p;
    for (int i = 0; i < 6; i++) begin
      digs[i] = t % 10;
      t = t / 10;
    end
    for (int i = 1; i < 6; i++) if (digs[i] != 0) msd = i;
`ifdef LEADING_ZERO_BLANK_EN
    p = d > msd ? ((s && d == msd + 1) ? 8'hBF : 8'hFF) : num_tab[digs[d]];
`else
    p = (s && d == 5) ? 8'hBF : num_tab[digs[d]];
`endif
    if (pt[d]) p[7] = 1'b0;
    return p;
  endfunction
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask
  // k counts clock edges since reset release; edge k+1 is an IDLE sample when k%22==0
  task automatic tick();
    int idx = (k / 10) % 6;
    logic [5:0] es;
    logic [7:0] eg;
    es = bus.seg_en ? 6'b1 << idx : 6'd0;
    eg = bus.seg_en ? exp_seg(buf_val, buf_sgn, bus.point, idx) : 8'hFF;
    if (k % 22 == 0) begin
      pend_val = clamp(int'(bus.data), bus.sign);
      pend_sgn = bus.sign;
    end
    if (k % 22 == 21) begin
      buf_val = pend_val;
      buf_sgn = pend_sgn;
    end
    @(posedge sys_clk);
    k++;
    @(negedge sys_clk);
    chk("sel", {2'b00, bus.sel}, {2'b00, es});
    chk("seg", bus.seg, eg);
  endtask
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    chk("rst_sel", {2'b00, bus.sel}, 8'h00);
    chk("rst_seg", bus.seg, 8'hFF);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    k = 0;
    buf_val = 0;
    buf_sgn = 1'b0;
  endtask
  initial begin
    bus.data = 20'd123456;
    bus.point = 6'd0;
    bus.sign = 1'b0;
    bus.seg_en = 1'b1;
    @(negedge sys_clk);
    do_reset();
    repeat (90) tick();
    bus.data = 20'd1000000;
    repeat (70) tick();
    bus.data = 20'd42;
    bus.sign = 1'b1;
    repeat (70) tick();
    bus.data = 20'd0;
    bus.sign = 1'b0;
    bus.point = 6'b000100;
    repeat (70) tick();
    bus.data = 20'd123456;
    bus.point = 6'd0;
    repeat (25) tick();
    bus.seg_en = 1'b0;
    repeat (13) tick();
    bus.seg_en = 1'b1;
    repeat (30) tick();
    bus.data = 20'd111111;
    repeat (50) tick();
    for (int w = 0; w < 22 && k % 22 != 11; w++) tick();
    bus.data = 20'd222222;
    do_reset();
    repeat (70) tick();
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: bus.data = 20'($urandom_range(0, 99));
        1: bus.data = 20'($urandom_range(0, 99999));
        default: bus.data = 20'($urandom_range(0, 20'hFFFFF));
      endcase
      bus.sign = 1'($urandom_range(0, 1));
      bus.point = 6'($urandom);
      bus.seg_en = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 9) == 0) do_reset();
      repeat ($urandom_range(5, 50)) tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
